// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_wait_timer and inst_fetch.
package fetch_pkg;

  localparam int          FETCH_AW     = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    ABORT
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Bus wait-state counter for fetch reads.
// Saturating; expired once the last allowed wait cycle is reached.
module fetch_wait_timer
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: req/ack read of instruction memory,
// holds the word for decode and stalls the PC.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [31:0] NOP_INST       = NOP_INST_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FETCH_AW-1:0] pc_value,
  input  logic                redirect,
  output logic                mem_req,
  output logic [FETCH_AW-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [31:0]         mem_rdata,
  output logic [31:0]         inst,
  output logic                inst_valid,
  output logic                inst_fault,
  input  logic                inst_ready,
  output logic                pc_stall
);

  fetch_state_e        state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [FETCH_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]         inst_q, inst_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;
  logic                expired;
  logic                tmr_clear;
  logic                tmr_en;

  assign tmr_clear = (state_q == IDLE);
  assign tmr_en    = ((state_q == REQ) || (state_q == ABORT))
                     && !mem_ack;

  fetch_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(expired)
  );

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        if (pc_value[1:0] != 2'b00) begin
          inst_d  = NOP_INST;
          valid_d = 1'b1;
          fault_d = 1'b1;
          state_d = HOLD;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_value;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (redirect) begin
            state_d = IDLE;
          end else begin
            inst_d  = mem_rdata;
            valid_d = 1'b1;
            fault_d = 1'b0;
            state_d = HOLD;
          end
        end else if (redirect) begin
          // Out of wait budget: nothing left to abort.
          if (expired) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = ABORT;
          end
        end else if (expired) begin
          mem_req_d = 1'b0;
          inst_d    = NOP_INST;
          valid_d   = 1'b1;
          fault_d   = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      ABORT: begin
        if (mem_ack || expired) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      inst_q     <= NOP_INST;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign inst_fault = fault_q;
  assign pc_stall   = !((state_q == HOLD) && inst_ready);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a handshake scoreboard.
// Expected words are queued by stimulus, popped by the monitor.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_value;
  logic        redirect;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_fault;
  logic        inst_ready;
  logic        pc_stall;

  int vectors = 0;
  int errors  = 0;
  logic [32:0] exp_q[$];
  bit done = 1'b0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc_value  (pc_value),
    .redirect  (redirect),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .inst      (inst),
    .inst_valid(inst_valid),
    .inst_fault(inst_fault),
    .inst_ready(inst_ready),
    .pc_stall  (pc_stall)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive();
    #1;
  endtask

  // Monitor: compare every word decode actually consumes.
  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", inst, 32'hFFFF_FFFF);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("sb_inst", inst, e[31:0]);
          chk("sb_fault", {31'b0, inst_fault}, {31'b0, e[32]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc_value = 32'h0; redirect = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b1;

    // Reset held for two edges.
    repeat (2) begin
      tick();
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_fault", {31'b0, inst_fault}, 32'd0);
    end
    drive(); rst = 1'b0;

    // First request right after reset.
    tick();
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    drive(); mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    exp_q.push_back({1'b0, 32'h1111_0000});
    tick();
    chk("w0_valid", {31'b0, inst_valid}, 32'd1);
    chk("w0_req_drop", {31'b0, mem_req}, 32'd0);
    drive(); mem_ack = 1'b0; pc_value = 32'h4;
    tick();
    chk("idle_valid", {31'b0, inst_valid}, 32'd0);
    chk("idle_inst", inst, 32'h0);
    chk("idle_stall", {31'b0, pc_stall}, 32'd1);

    // Zero-wait read at 0x4.
    tick();
    chk("zw_req", {31'b0, mem_req}, 32'd1);
    chk("zw_addr", mem_addr, 32'h4);
    chk("zw_stall_req", {31'b0, pc_stall}, 32'd1);
    drive(); mem_ack = 1'b1; mem_rdata = 32'h2408_0005;
    exp_q.push_back({1'b0, 32'h2408_0005});
    tick();
    chk("zw_inst", inst, 32'h2408_0005);
    chk("zw_valid", {31'b0, inst_valid}, 32'd1);
    chk("zw_stall", {31'b0, pc_stall}, 32'd0);
    drive(); mem_ack = 1'b0; pc_value = 32'h8;

    // Three wait states, then four cycles of backpressure.
    tick();
    tick();
    chk("ws_addr", mem_addr, 32'h8);
    repeat (3) begin
      chk("ws_req", {31'b0, mem_req}, 32'd1);
      chk("ws_valid", {31'b0, inst_valid}, 32'd0);
      tick();
    end
    drive(); mem_ack = 1'b1; mem_rdata = 32'hA5A5_0008;
    inst_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hA5A5_0008});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_inst", inst, 32'hA5A5_0008);
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_stall", {31'b0, pc_stall}, 32'd1);
      drive(); mem_ack = 1'b0;
    end
    inst_ready = 1'b1; pc_value = 32'hC;
    #1;
    chk("bp_release", {31'b0, pc_stall}, 32'd0);
    tick();
    chk("bp_consumed", {31'b0, inst_valid}, 32'd0);

    // Redirect while the read at 0xC is outstanding.
    tick();
    chk("rd_req", {31'b0, mem_req}, 32'd1);
    chk("rd_addr", mem_addr, 32'hC);
    drive(); redirect = 1'b1; pc_value = 32'h0;
    tick();
    chk("ab_req", {31'b0, mem_req}, 32'd1);
    chk("ab_addr", mem_addr, 32'hC);
    drive(); redirect = 1'b0;
    tick();
    drive(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ab_drop", {31'b0, mem_req}, 32'd0);
    chk("ab_valid", {31'b0, inst_valid}, 32'd0);
    drive(); mem_ack = 1'b0;
    tick();
    chk("rd_new_req", {31'b0, mem_req}, 32'd1);
    chk("rd_new_addr", mem_addr, 32'h0);
    drive(); mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    exp_q.push_back({1'b0, 32'h0000_0013});
    tick();
    chk("rd_new_inst", inst, 32'h0000_0013);
    drive(); mem_ack = 1'b0; pc_value = 32'h10;

    // Bus timeout: no ack ever arrives.
    exp_q.push_back({1'b1, 32'h0});
    tick();
    tick();
    chk("to_addr", mem_addr, 32'h10);
    for (int i = 0; i < 15; i++) begin
      chk("to_req_hold", {31'b0, mem_req}, 32'd1);
      tick();
    end
    chk("to_req_fall", {31'b0, mem_req}, 32'd0);
    chk("to_valid", {31'b0, inst_valid}, 32'd1);
    chk("to_fault", {31'b0, inst_fault}, 32'd1);
    chk("to_inst", inst, 32'h0);
    drive(); pc_value = 32'h6;

    // Misaligned PC: fault without touching the bus.
    exp_q.push_back({1'b1, 32'h0});
    tick();
    chk("ma_idle", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("ma_req", {31'b0, mem_req}, 32'd0);
    chk("ma_valid", {31'b0, inst_valid}, 32'd1);
    chk("ma_fault", {31'b0, inst_fault}, 32'd1);
    chk("ma_inst", inst, 32'h0);
    drive(); pc_value = 32'h14;
    tick();
    chk("ma_consumed", {31'b0, inst_valid}, 32'd0);

    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    done = 1'b1;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
